// File: rtl/pipelined_wide_adder_pkg.sv
// Shared helpers for the chunked carry-pipelined adder: stage-count derivation.
package pipelined_wide_adder_pkg;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_wide_adder_add_chunk.sv
// add_chunk: W-bit combinational ripple adder slice, no state, no flow control.
module add_chunk #(
  parameter int W = 4
) (
  output logic [W-1:0] s,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_wide_adder.sv
// Carry-pipelined add/sub, one CHUNK slice per stage; latency STAGES, whole pipe holds when in_ready==0.
// Optional PIPE_ADD_OVF_EN adds a pipelined signed-overflow output (ovf).
module pipelined_wide_adder
  import pipelined_wide_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("pipelined_wide_adder: WIDTH must be a multiple of CHUNK");
  end

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_co;
  logic              w_adv;
  logic              w_c0;
  logic [WIDTH-1:0]  w_b_eff;
  logic [CHUNK-1:0]  w_a_st [STAGES];
  logic [CHUNK-1:0]  w_b_st [STAGES];
  logic [CHUNK-1:0]  w_s_st [STAGES];

  assign out_valid = r_vld[STAGES-1];
  assign in_ready  = ~out_valid | out_ready;
  assign w_adv     = in_ready;
  assign w_b_eff   = sub ? ~b : b;
  assign w_c0      = sub ? ~cin : cin;
  assign cout      = r_c[STAGES-1];
  // A stage register only loads when valid data is entering it, so idle outputs keep their value.
  assign w_en      = w_vin & {STAGES{w_adv}};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_c   <= '0;
    end else begin
      if (w_adv) r_vld <= w_vin;
      for (int k = 0; k < STAGES; k++) begin
        if (w_en[k]) r_c[k] <= w_co[k];
      end
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    if (j == 0) begin : g_direct
      assign w_vin[0]  = in_valid;
      assign w_cin[0]  = w_c0;
      assign w_a_st[0] = a[CHUNK-1:0];
      assign w_b_st[0] = w_b_eff[CHUNK-1:0];
    end else begin : g_skew
      logic [CHUNK-1:0] r_ask [j];
      logic [CHUNK-1:0] r_bsk [j];

      assign w_vin[j] = r_vld[j-1];
      assign w_cin[j] = r_c[j-1];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < j; i++) begin
            r_ask[i] <= '0;
            r_bsk[i] <= '0;
          end
        end else begin
          if (w_en[0]) begin
            r_ask[0] <= a[j*CHUNK +: CHUNK];
            r_bsk[0] <= w_b_eff[j*CHUNK +: CHUNK];
          end
          for (int i = 1; i < j; i++) begin
            if (w_en[i]) begin
              r_ask[i] <= r_ask[i-1];
              r_bsk[i] <= r_bsk[i-1];
            end
          end
        end
      end

      assign w_a_st[j] = r_ask[j-1];
      assign w_b_st[j] = r_bsk[j-1];
    end

    add_chunk #(.W(CHUNK)) u_add (
      .s    (w_s_st[j]),
      .cout (w_co[j]),
      .a    (w_a_st[j]),
      .b    (w_b_st[j]),
      .cin  (w_cin[j])
    );

    // Deskew: slice j finishes at stage j and waits STAGES-1-j more stages for the upper slices.
    logic [CHUNK-1:0] r_res [STAGES-j];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < STAGES - j; i++) r_res[i] <= '0;
      end else begin
        if (w_en[j]) r_res[0] <= w_s_st[j];
        for (int i = 1; i < STAGES - j; i++) begin
          if (w_en[j+i]) r_res[i] <= r_res[i-1];
        end
      end
    end

    assign sum[j*CHUNK +: CHUNK] = r_res[STAGES-j-1];
  end

`ifdef PIPE_ADD_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_en[STAGES-1]) begin
      r_ovf <= (w_a_st[STAGES-1][CHUNK-1] == w_b_st[STAGES-1][CHUNK-1]) &&
               (w_s_st[STAGES-1][CHUNK-1] != w_a_st[STAGES-1][CHUNK-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_wide_adder.sv
// Directed bench for pipelined_wide_adder (WIDTH=16, CHUNK=4): latency, throughput, stall, reset, ovf.
module tb_pipelined_wide_adder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef PIPE_ADD_OVF_EN
  logic        ovf;
`endif

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t tv [8];

  pipelined_wide_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_and_wait(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                               input logic icin, input logic isub,
                               input logic [15:0] es, input logic ec);
    int lat;
    in_valid  = 1'b1;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    check_eq({tag, "_sum"}, 32'(sum), 32'(es));
    check_eq({tag, "_cout"}, 32'(cout), 32'(ec));
  endtask

  initial begin
    int idx;
    int got;
    int ghosts;

    tv[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    tv[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    tv[2] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1};
    tv[3] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0};
    tv[4] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0};
    tv[5] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0};
    tv[6] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1};
    tv[7] = '{16'hC000, 16'h8000, 1'b0, 1'b0, 16'h4000, 1'b1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    check_eq("rst_rdy", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    send_and_wait("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    send_and_wait("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    send_and_wait("sub_cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1);

    // Back-to-back: results expected after edges 4..11 only.
    out_ready = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      if (e <= 8) begin
        in_valid = 1'b1;
        a   = tv[e-1].a;
        b   = tv[e-1].b;
        cin = tv[e-1].cin;
        sub = tv[e-1].sub;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check_eq($sformatf("tput_rdy%0d", e), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check_eq($sformatf("tput_vld%0d", e), 32'(out_valid), 32'((e >= 4 && e <= 11) ? 1 : 0));
      if (out_valid && e >= 4 && e <= 11) begin
        check_eq($sformatf("tput_sum%0d", e), 32'(sum), 32'(tv[e-4].s));
        check_eq($sformatf("tput_cout%0d", e), 32'(cout), 32'(tv[e-4].co));
      end
    end

    // Stall three cycles on the first result with the source still pushing.
    idx = 0;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        a   = tv[idx].a;
        b   = tv[idx].b;
        cin = tv[idx].cin;
        sub = tv[idx].sub;
      end
      #1;
      if (c >= 4 && c <= 6) begin
        check_eq($sformatf("stall_rdy%0d", c), 32'(in_ready), 32'd0);
        check_eq($sformatf("stall_vld%0d", c), 32'(out_valid), 32'd1);
        check_eq($sformatf("stall_sum%0d", c), 32'(sum), 32'(tv[0].s));
      end
      if (out_valid && out_ready) begin
        if (got < 8) begin
          check_eq($sformatf("stall_out_sum%0d", got), 32'(sum), 32'(tv[got].s));
          check_eq($sformatf("stall_out_cout%0d", got), 32'(cout), 32'(tv[got].co));
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    check_eq("stall_accepted", 32'(idx), 32'd8);
    check_eq("stall_delivered", 32'(got), 32'd8);

    // Three sets in flight, then a one-edge reset just before the first would emerge.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a   = tv[i].a;
      b   = tv[i].b;
      cin = tv[i].cin;
      sub = tv[i].sub;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_eq("mid_rst_vld", 32'(out_valid), 32'd0);
    check_eq("mid_rst_sum", 32'(sum), 32'd0);
    check_eq("mid_rst_cout", 32'(cout), 32'd0);
    ghosts = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) ghosts++;
    end
    check_eq("mid_rst_ghosts", 32'(ghosts), 32'd0);
    send_and_wait("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);

`ifdef PIPE_ADD_OVF_EN
    send_and_wait("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
    check_eq("ovf_pos_ovf", 32'(ovf), 32'd1);
    send_and_wait("ovf_neg", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
    check_eq("ovf_neg_ovf", 32'(ovf), 32'd1);
    send_and_wait("ovf_none", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    check_eq("ovf_none_ovf", 32'(ovf), 32'd0);
`endif

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
